// File: rtl/fifo_ack_rd_packer_pkg.sv
// Shared types and helpers for the ack-style read-side word packer.
// Holds the FSM state encoding and the log2 helper used to size word counters.
package fifo_ack_rd_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Ceiling log2, evaluated at elaboration time to size counters.
  function automatic int func_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ack_rd_packer.sv
// Drains narrow words from an ack-style FIFO read port, packs RATIO words per beat
// and pushes beats into a val/ful write port; a sticky flush emits partial beats.
module fifo_ack_rd_packer
  import fifo_ack_rd_packer_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter int RATIO   = 4,
  localparam int CNT_WD = func_log2(RATIO) + 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       up_rdy_i,
  output logic                       up_ack_o,
  input  logic [DATA_WD-1:0]         up_dat_i,
  input  logic                       flu_i,
  output logic                       dn_val_o,
  output logic [DATA_WD*RATIO-1:0]   dn_dat_o,
  output logic [CNT_WD-1:0]          dn_cnt_o,
  input  logic                       dn_ful_i,
  output logic [CNT_WD-1:0]          acc_cnt_o
);

  localparam int BEAT_WD = DATA_WD * RATIO;
  localparam logic [CNT_WD-1:0] LAST_LANE = CNT_WD'(RATIO - 1);
  localparam logic [CNT_WD-1:0] FULL_CNT  = CNT_WD'(RATIO);

  state_t               state_q;
  state_t               state_d;
  logic [BEAT_WD-1:0]   acc_q;
  logic [BEAT_WD-1:0]   acc_next;
  logic [BEAT_WD-1:0]   beat_data;
  logic [CNT_WD-1:0]    acc_cnt_q;
  logic [CNT_WD-1:0]    acc_cnt_d;
  logic [CNT_WD-1:0]    word_cnt;
  logic [BEAT_WD-1:0]   dat_q;
  logic [CNT_WD-1:0]    cnt_q;
  logic                 pnd_q;
  logic                 slot_free;
  logic                 flush_req;
  logic                 load;

  assign dn_val_o  = pnd_q && !dn_ful_i;
  assign slot_free = !pnd_q || dn_val_o;
  assign up_ack_o  = up_rdy_i && (state_q != ST_FLUSH) &&
                     ((acc_cnt_q < LAST_LANE) || slot_free);

  // Words held after this cycle, counting the one being acked now.
  assign word_cnt  = acc_cnt_q + {{(CNT_WD-1){1'b0}}, up_ack_o};
  assign flush_req = flu_i || (state_q == ST_FLUSH);

  assign dn_dat_o  = dat_q;
  assign dn_cnt_o  = cnt_q;
  assign acc_cnt_o = acc_cnt_q;

  // The acked word lands in lane acc_cnt_q; the beat masks lanes past word_cnt,
  // so a full beat and a partial beat share one datapath.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign acc_next[k*DATA_WD +: DATA_WD] =
      (up_ack_o && (acc_cnt_q == CNT_WD'(k))) ? up_dat_i : acc_q[k*DATA_WD +: DATA_WD];
    assign beat_data[k*DATA_WD +: DATA_WD] =
      (CNT_WD'(k) < word_cnt) ? acc_next[k*DATA_WD +: DATA_WD] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    acc_cnt_d = word_cnt;
    if (word_cnt == FULL_CNT) begin
      // A completed beat also satisfies any flush raised this cycle.
      load      = 1'b1;
      acc_cnt_d = '0;
      state_d   = ST_IDLE;
    end else if (flush_req && (word_cnt != '0)) begin
      if (slot_free) begin
        load      = 1'b1;
        acc_cnt_d = '0;
        state_d   = ST_IDLE;
      end else begin
        state_d   = ST_FLUSH;
      end
    end else begin
      state_d = (word_cnt == '0) ? ST_IDLE : ST_FILL;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
    end else begin
      acc_q     <= acc_next;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  // Slot contents only change on a load, so they stay stable while pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pnd_q <= 1'b0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load) begin
        pnd_q <= 1'b1;
        dat_q <= beat_data;
        cnt_q <= word_cnt;
      end else if (dn_val_o) begin
        pnd_q <= 1'b0;
      end
    end
  end

`ifdef SIM_KNOB_DBG
  a_val_while_full : assert property (@(posedge clk) disable iff (!rstn)
    !(dn_val_o && dn_ful_i))
    else $error("dn_val_o asserted while dn_ful_i is high");
  a_ack_without_rdy : assert property (@(posedge clk) disable iff (!rstn)
    !(up_ack_o && !up_rdy_i))
    else $error("up_ack_o asserted without up_rdy_i");
  a_empty_beat : assert property (@(posedge clk) disable iff (!rstn)
    !(dn_val_o && (dn_cnt_o == '0)))
    else $error("dn_val_o asserted with dn_cnt_o of zero");
`endif

endmodule

// File: tb/tb_fifo_ack_rd_packer.sv
// Self-checking bench for fifo_ack_rd_packer (DATA_WD=8, RATIO=4): directed table,
// hand-written backpressure/flush/reset sequences and a randomized run against a queue model.
module tb_fifo_ack_rd_packer;

  localparam int DATA_WD = 8;
  localparam int RATIO   = 4;
  localparam int CNT_WD  = 3;

  logic                     clk;
  logic                     rstn;
  logic                     up_rdy_i;
  logic                     up_ack_o;
  logic [DATA_WD-1:0]       up_dat_i;
  logic                     flu_i;
  logic                     dn_val_o;
  logic [DATA_WD*RATIO-1:0] dn_dat_o;
  logic [CNT_WD-1:0]        dn_cnt_o;
  logic                     dn_ful_i;
  logic [CNT_WD-1:0]        acc_cnt_o;

  fifo_ack_rd_packer #(.DATA_WD(DATA_WD), .RATIO(RATIO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .up_rdy_i  (up_rdy_i),
    .up_ack_o  (up_ack_o),
    .up_dat_i  (up_dat_i),
    .flu_i     (flu_i),
    .dn_val_o  (dn_val_o),
    .dn_dat_o  (dn_dat_o),
    .dn_cnt_o  (dn_cnt_o),
    .dn_ful_i  (dn_ful_i),
    .acc_cnt_o (acc_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          rdy;
    logic [7:0]  dat;
    bit          flu;
    bit          ful;
    bit          ack;
    bit          val;
    logic [2:0]  acc;
    bit          chk;
    logic [31:0] bdat;
    logic [2:0]  bcnt;
  } vec_t;

  vec_t vecs[20];

  // Behavioural model: words held, pending beat, and a sticky flush flag.
  int          mq[$];
  bit          m_pnd;
  logic [31:0] m_dat;
  int          m_cnt;
  bit          m_flushing;

  logic [31:0] log_dat[$];
  int          log_cnt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] log_d(input int i);
    return (i < log_dat.size()) ? log_dat[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int log_c(input int i);
    return (i < log_cnt.size()) ? log_cnt[i] : -1;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pnd      = 1'b0;
    m_dat      = '0;
    m_cnt      = 0;
    m_flushing = 1'b0;
  endfunction

  // One clock cycle: drive, check at negedge against the model, advance the model.
  task automatic cycle(input bit rdy, input logic [7:0] dat, input bit flu, input bit ful,
                       output bit acked);
    bit m_val, m_free, m_ack, m_load;
    up_rdy_i = rdy;
    up_dat_i = dat;
    flu_i    = flu;
    dn_ful_i = ful;
    @(negedge clk);
    m_val  = m_pnd && !ful;
    m_free = !m_pnd || m_val;
    m_ack  = rdy && !m_flushing && ((mq.size() < RATIO - 1) || m_free);
    chk("ack", {31'b0, up_ack_o}, {31'b0, m_ack});
    chk("val", {31'b0, dn_val_o}, {31'b0, m_val});
    chk("acc_cnt", {29'b0, acc_cnt_o}, mq.size());
    if (m_pnd) begin
      chk("beat_dat", dn_dat_o, m_dat);
      chk("beat_cnt", {29'b0, dn_cnt_o}, m_cnt);
    end
    if (dn_val_o) begin
      log_dat.push_back(dn_dat_o);
      log_cnt.push_back(int'(dn_cnt_o));
    end
    acked  = up_ack_o;
    m_load = 1'b0;
    if (m_ack) mq.push_back(int'(dat));
    if (mq.size() == RATIO) m_load = 1'b1;
    else if ((flu || m_flushing) && mq.size() > 0) begin
      if (m_free) m_load = 1'b1;
      else        m_flushing = 1'b1;
    end
    if (m_load) begin
      m_dat = '0;
      foreach (mq[i]) m_dat |= 32'(mq[i]) << (8 * i);
      m_cnt      = mq.size();
      mq.delete();
      m_flushing = 1'b0;
      m_pnd      = 1'b1;
    end else if (m_val) begin
      m_pnd = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    up_rdy_i = 1'b0;
    up_dat_i = '0;
    flu_i    = 1'b0;
    dn_ful_i = 1'b0;
    rstn     = 1'b0;
    #3;
    chk("rst_val", {31'b0, dn_val_o}, 32'd0);
    chk("rst_dat", dn_dat_o, 32'd0);
    chk("rst_cnt", {29'b0, dn_cnt_o}, 32'd0);
    chk("rst_acc", {29'b0, acc_cnt_o}, 32'd0);
    chk("rst_ack", {31'b0, up_ack_o}, 32'd0);
    #9;
    rstn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit a;
    int idx;

    vecs[0]  = '{1, 8'h01, 0, 0, 1, 0, 3'd0, 0, 32'h0,        3'd0};
    vecs[1]  = '{1, 8'h02, 0, 0, 1, 0, 3'd1, 0, 32'h0,        3'd0};
    vecs[2]  = '{1, 8'h03, 0, 0, 1, 0, 3'd2, 0, 32'h0,        3'd0};
    vecs[3]  = '{1, 8'h04, 0, 0, 1, 0, 3'd3, 0, 32'h0,        3'd0};
    vecs[4]  = '{1, 8'h05, 0, 0, 1, 1, 3'd0, 1, 32'h04030201, 3'd4};
    vecs[5]  = '{1, 8'h06, 0, 0, 1, 0, 3'd1, 0, 32'h0,        3'd0};
    vecs[6]  = '{1, 8'h07, 0, 0, 1, 0, 3'd2, 0, 32'h0,        3'd0};
    vecs[7]  = '{1, 8'h08, 0, 0, 1, 0, 3'd3, 0, 32'h0,        3'd0};
    vecs[8]  = '{0, 8'h00, 0, 0, 0, 1, 3'd0, 1, 32'h08070605, 3'd4};
    vecs[9]  = '{0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 32'h0,        3'd0};
    vecs[10] = '{1, 8'hA1, 0, 0, 1, 0, 3'd0, 0, 32'h0,        3'd0};
    vecs[11] = '{1, 8'hA2, 0, 0, 1, 0, 3'd1, 0, 32'h0,        3'd0};
    vecs[12] = '{0, 8'h00, 1, 0, 0, 0, 3'd2, 0, 32'h0,        3'd0};
    vecs[13] = '{0, 8'h00, 0, 0, 0, 1, 3'd0, 1, 32'h0000A2A1, 3'd2};
    vecs[14] = '{1, 8'hA1, 0, 0, 1, 0, 3'd0, 0, 32'h0,        3'd0};
    vecs[15] = '{1, 8'hA2, 0, 0, 1, 0, 3'd1, 0, 32'h0,        3'd0};
    vecs[16] = '{1, 8'hA3, 1, 0, 1, 0, 3'd2, 0, 32'h0,        3'd0};
    vecs[17] = '{0, 8'h00, 0, 0, 0, 1, 3'd0, 1, 32'h00A3A2A1, 3'd3};
    vecs[18] = '{0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 32'h0,        3'd0};
    vecs[19] = '{0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 32'h0,        3'd0};

    applyReset();

    // Directed table: streaming, partial flush, flush with same-cycle word, idle flush.
    for (int i = 0; i < 20; i++) begin
      up_rdy_i = vecs[i].rdy;
      up_dat_i = vecs[i].dat;
      flu_i    = vecs[i].flu;
      dn_ful_i = vecs[i].ful;
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", i), {31'b0, up_ack_o}, {31'b0, vecs[i].ack});
      chk($sformatf("tbl%0d_val", i), {31'b0, dn_val_o}, {31'b0, vecs[i].val});
      chk($sformatf("tbl%0d_acc", i), {29'b0, acc_cnt_o}, {29'b0, vecs[i].acc});
      if (vecs[i].chk) begin
        chk($sformatf("tbl%0d_dat", i), dn_dat_o, vecs[i].bdat);
        chk($sformatf("tbl%0d_cnt", i), {29'b0, dn_cnt_o}, {29'b0, vecs[i].bcnt});
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: 8 words offered while downstream is full.
    applyReset();
    log_dat.delete();
    log_cnt.delete();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(idx < 8, 8'(8'h11 + idx), 1'b0, 1'b1, a);
      if (a) idx++;
    end
    chk("bp_acks_while_full", idx, 7);
    for (int c = 0; c < 8; c++) begin
      cycle(idx < 8, 8'(8'h11 + idx), 1'b0, 1'b0, a);
      if (a) idx++;
    end
    chk("bp_words", idx, 8);
    chk("bp_beats", log_dat.size(), 2);
    chk("bp_beat0", log_d(0), 32'h14131211);
    chk("bp_beat1", log_d(1), 32'h18171615);
    chk("bp_cnt1", log_c(1), 4);

    // Flush while a full beat is pending: partial beat must follow it.
    log_dat.delete();
    log_cnt.delete();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 8'(8'h21 + idx), 1'b0, 1'b1, a);
      if (a) idx++;
    end
    chk("fp_words", idx, 6);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, a);
    for (int c = 0; c < 2; c++) begin
      cycle(1'b1, 8'h27, 1'b1, 1'b1, a);
      chk("fp_hold_ack", {31'b0, a}, 32'd0);
    end
    for (int c = 0; c < 3; c++) cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
    chk("fp_beats", log_dat.size(), 2);
    chk("fp_beat0", log_d(0), 32'h24232221);
    chk("fp_beat1", log_d(1), 32'h00002625);
    chk("fp_cnt1", log_c(1), 2);

    // Asynchronous reset with two words held and a beat pending.
    for (int c = 0; c < 6; c++) cycle(1'b1, 8'(8'h41 + c), 1'b0, 1'b1, a);
    chk("rs_pre_acc", {29'b0, acc_cnt_o}, 32'd2);
    up_rdy_i = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("rs_val", {31'b0, dn_val_o}, 32'd0);
    chk("rs_dat", dn_dat_o, 32'd0);
    chk("rs_cnt", {29'b0, dn_cnt_o}, 32'd0);
    chk("rs_acc", {29'b0, acc_cnt_o}, 32'd0);
    chk("rs_ack", {31'b0, up_ack_o}, 32'd0);
    #10;
    rstn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    log_dat.delete();
    log_cnt.delete();
    for (int c = 0; c < 4; c++) cycle(1'b1, 8'(8'h31 + c), 1'b0, 1'b0, a);
    for (int c = 0; c < 2; c++) cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
    chk("rs_beats", log_dat.size(), 1);
    chk("rs_beat0", log_d(0), 32'h34333231);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 3, a);
    end
    for (int c = 0; c < 6; c++) cycle(1'b0, 8'h00, 1'b0, 1'b0, a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
